// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared definitions for the sequenced execute unit.
//   - 4-bit ALU opcode map (kADD..kSLT); values above kOPMAX are illegal.
//   - alu_state_t: control states of alu_iter.
//   - is_shift(): identifies the multi-cycle shift opcodes.
package alu_iter_pkg;

    localparam logic [3:0] kADD = 4'd0;
    localparam logic [3:0] kSUB = 4'd1;
    localparam logic [3:0] kAND = 4'd2;
    localparam logic [3:0] kOR  = 4'd3;
    localparam logic [3:0] kXOR = 4'd4;
    localparam logic [3:0] kLSH = 4'd5;
    localparam logic [3:0] kRSH = 4'd6;
    localparam logic [3:0] kSEQ = 4'd7;
    localparam logic [3:0] kSLT = 4'd8;

    localparam logic [3:0] kOPMAX = kSLT;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == kLSH) || (op == kRSH);
    endfunction

endpackage

// File: rtl/alu_iter_comb.sv
// alu_comb: purely combinational ALU core for alu_iter.
//   op      : opcode from the shared map
//   a, b    : operands (for LSH/RSH, a is the already-shifted value)
//   result  : W-bit result (0 for illegal opcodes)
//   carry   : ADD carry-out, SUB borrow (a < b unsigned), 0 otherwise
//   illegal : op > kOPMAX
module alu_comb
    import alu_iter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         illegal
);

    logic [W:0] sum;
    logic [W:0] diff;

    // Extra top bit holds carry-out for ADD and borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            kADD: begin
                result = sum[W-1:0];
                carry  = sum[W];
            end
            kSUB: begin
                result = diff[W-1:0];
                carry  = diff[W];
            end
            kAND: result = a & b;
            kOR:  result = a | b;
            kXOR: result = a ^ b;
            // Shifting is done iteratively by the caller; a arrives shifted.
            kLSH, kRSH: result = a;
            kSEQ: result = {{(W-1){1'b0}}, (a == b)};
            kSLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: sequenced execute unit with valid/ready on both sides.
//   Clk, Reset          : clock, synchronous active-high reset
//   InValid/InReady     : request handshake (InReady high only in IDLE)
//   Op, InA, InB        : opcode and operands, captured on accept
//   OutValid/OutReady   : result handshake (OutValid high only in DONE)
//   Out, Zero, Carry,
//   Illegal             : registered result, held until taken
// Every accepted op spends one execute cycle in SHIFT with a zero count,
// giving a 1-cycle latency; LSH/RSH by k add k one-bit shift cycles first.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [3:0]   Op,
    input  logic [W-1:0] InA,
    input  logic [W-1:0] InB,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic         Carry,
    output logic         Illegal
);

    alu_state_t     state, state_next;
    logic [3:0]     op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [SHW-1:0] cnt;
    logic [W-1:0]   res;
    logic           res_carry;
    logic           res_illegal;
    logic           exec_done;

    assign exec_done = (state == SHIFT) && (cnt == '0);

    alu_comb #(.W(W)) u_comb (
        .op      (op_r),
        .a       (a_r),
        .b       (b_r),
        .result  (res),
        .carry   (res_carry),
        .illegal (res_illegal)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        InReady    = 1'b0;
        OutValid   = 1'b0;
        case (state)
            IDLE: begin
                InReady = 1'b1;
                if (InValid) state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accept, then one zero-fill shift per SHIFT cycle
    // until the count is exhausted.
    always_ff @(posedge Clk) begin
        if (state == IDLE && InValid) begin
            op_r <= Op;
            a_r  <= InA;
            b_r  <= InB;
            cnt  <= is_shift(Op) ? InB[SHW-1:0] : '0;
        end else if (state == SHIFT && cnt != '0) begin
            a_r <= (op_r == kLSH) ? (a_r << 1) : (a_r >> 1);
            cnt <= cnt - SHW'(1);
        end
    end

    // Result registers: loaded on the execute cycle, held through DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out     <= '0;
            Zero    <= 1'b0;
            Carry   <= 1'b0;
            Illegal <= 1'b0;
        end else if (exec_done) begin
            Out     <= res;
            Zero    <= (res == '0);
            Carry   <= res_carry;
            Illegal <= res_illegal;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed scoreboard bench for alu_iter.
module tb_alu_iter;
    import alu_iter_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       InValid;
    logic       InReady;
    logic [3:0] Op;
    logic [7:0] InA;
    logic [7:0] InB;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] Out;
    logic       Zero;
    logic       Carry;
    logic       Illegal;

    alu_iter #(.W(8), .SHW(3)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Op       (Op),
        .InA      (InA),
        .InB      (InB),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Out      (Out),
        .Zero     (Zero),
        .Carry    (Carry),
        .Illegal  (Illegal)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic       zero;
        logic       carry;
        logic       illegal;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   first_c = 0;
    logic prev_ov = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: samples 2 time units after the falling edge, after the
    // driver has updated its inputs for the coming rising edge.
    always @(negedge Clk) begin
        #2;
        if (OutValid && InReady) begin
            vectors++;
            fails++;
            $display("FAIL ready_valid_overlap: got both high at cycle %0d, required never together", cyc);
        end
        if (OutValid && !prev_ov) first_c = cyc;
        prev_ov = OutValid;
        if (OutValid && OutReady) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got out=%h with no pending op, required none", Out);
            end else begin
                e = sb.pop_front();
                if (Out !== e.out || Zero !== e.zero || Carry !== e.carry ||
                    Illegal !== e.illegal || (first_c - e.acc) != e.lat) begin
                    fails++;
                    $display("FAIL %s: got out=%h z=%b c=%b ill=%b lat=%0d, required out=%h z=%b c=%b ill=%b lat=%0d",
                             e.name, Out, Zero, Carry, Illegal, first_c - e.acc,
                             e.out, e.zero, e.carry, e.illegal, e.lat);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic ez,
                         input logic ec, input logic ei, input int lat);
        int n = 0;
        @(negedge Clk);
        Op = op; InA = a; InB = b; InValid = 1'b1;
        while (!InReady && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!InReady) begin
            vectors++;
            fails++;
            $display("FAIL %s_accept: got no InReady in 200 cycles, required accept", nm);
            InValid = 1'b0;
            return;
        end
        sb.push_back('{name: nm, out: eo, zero: ez, carry: ec, illegal: ei, lat: lat, acc: cyc + 1});
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        Op = 4'd0; InA = 8'h00; InB = 8'h00;
        repeat (2) @(negedge Clk);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_inready",  32'(InReady),  32'd1);
        chk("rst_out",      32'(Out),      32'd0);
        chk("rst_flags",    {29'd0, Zero, Carry, Illegal}, 32'd0);
        Reset = 1'b0;

        // Basic one-cycle ops
        issue("add_carry",  kADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1);
        issue("sub_borrow", kSUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1);
        issue("slt_neg",    kSLT, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        issue("slt_pos",    kSLT, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        issue("seq_eq",     kSEQ, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        issue("seq_ne",     kSEQ, 8'h5A, 8'h5B, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        issue("xor_zero",   kXOR, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        issue("and",        kAND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1);
        issue("or",         kOR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
        issue("sub_equal",  kSUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        issue("add_wrap",   kADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        // Shifts: latency 1 + amount, only the low 3 bits of B count
        issue("rsh_7",      kRSH, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 8);
        issue("lsh_8_is_0", kLSH, 8'h3C, 8'h08, 8'h3C, 1'b0, 1'b0, 1'b0, 1);
        issue("lsh_3",      kLSH, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4);
        issue("rsh_1",      kRSH, 8'hA5, 8'h01, 8'h52, 1'b0, 1'b0, 1'b0, 2);
        issue("lsh_out",    kLSH, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8);
        // Illegal opcodes
        issue("illegal_c",  4'hC, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        issue("illegal_9",  4'h9, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        drain("basic");

        // Reset in the middle of a shift discards the op
        issue("pre_reset",  kADD, 8'h40, 8'h41, 8'h81, 1'b0, 1'b0, 1'b0, 1);
        drain("pre_reset");
        @(negedge Clk);
        Op = kLSH; InA = 8'h01; InB = 8'h07; InValid = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midrst_outvalid", 32'(OutValid), 32'd0);
        chk("midrst_inready",  32'(InReady),  32'd1);
        chk("midrst_out",      32'(Out),      32'd0);
        chk("midrst_flags",    {29'd0, Zero, Carry, Illegal}, 32'd0);
        issue("post_reset_add", kADD, 8'h07, 8'h08, 8'h0F, 1'b0, 1'b0, 1'b0, 1);
        drain("post_reset");

        // Backpressure: result held, new request ignored until taken
        OutReady = 1'b0;
        issue("bp_add", kADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1);
        n = 0;
        while (!OutValid && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("bp_outvalid_seen", 32'(OutValid), 32'd1);
        Op = kSUB; InA = 8'h09; InB = 8'h04; InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_out_stable",  32'(Out),      32'h03);
            chk("bp_inready_low", 32'(InReady),  32'd0);
            chk("bp_outvalid",    32'(OutValid), 32'd1);
        end
        sb.push_back('{name: "bp_sub", out: 8'h05, zero: 1'b0, carry: 1'b0, illegal: 1'b0, lat: 1, acc: cyc + 2});
        OutReady = 1'b1;
        @(negedge Clk);
        chk("bp_release_inready", 32'(InReady),  32'd1);
        chk("bp_release_ovalid",  32'(OutValid), 32'd0);
        @(negedge Clk);
        InValid = 1'b0;
        chk("bp_accepted", 32'(InReady), 32'd0);
        drain("backpressure");

        repeat (3) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
# alu_iter

Sequenced execute unit: the consumer of the 4-bit ALU opcode map (kADD..kSLT) produced by the instruction decoder. It accepts one operation at a time over a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. LSH/RSH iterate one bit per cycle. The result is held in an output register until the writeback stage takes it.

## Interface
Parameters:
- W, 8, operand/result width
- SHW, 3, shift-amount width; only InB[SHW-1:0] is used for LSH/RSH

Ports:
- Clk  input  1  single clock, rising edge
- Reset  input  1  synchronous, active-high
- InValid  input  1  decoder presents Op/InA/InB
- InReady  output  1  unit can accept; high only in IDLE
- Op  input  4  opcode from the shared opcode map
- InA  input  W  operand A
- InB  input  W  operand B / shift amount
- OutValid  output  1  Out/Zero/Carry/Illegal valid
- OutReady  input  1  writeback takes result
- Out  output  W  result
- Zero  output  1  Out == 0
- Carry  output  1  ADD carry-out; SUB borrow; 0 for other ops
- Illegal  output  1  Op > kSLT (values 9..15)

## Operation
- Accept: InValid && InReady on a rising edge. Op, InA and InB are captured; the source must not change them before accept.
- States:
  - IDLE: InReady=1. On accept of a shift with amount > 0, go to SHIFT. On any other accept, compute, register the result, go to DONE.
  - SHIFT: one 1-bit shift per cycle on the internal register; zero fill both directions (logical). When the count reaches 0, go to DONE.
  - DONE: OutValid=1. On OutReady, go to IDLE.
- Arithmetic (all modulo 2^W):
  - ADD: Carry = bit W of the (W+1)-bit sum.
  - SUB: Out = A-B; Carry = 1 when A < B unsigned.
  - AND/OR/XOR: bitwise.
  - SEQ: Out = 1 if A==B, else 0.
  - SLT: Out = 1 if A < B signed two's complement, else 0.
- Illegal Op: Out=0, Zero=1, Carry=0, Illegal=1. Completes like a 1-cycle op; it is never dropped.
- Zero is computed from the final Out, including for SEQ/SLT.

## Timing
- Reset (synchronous, any state, including mid-SHIFT): next edge enters IDLE. Out=0, Zero=0, Carry=0, Illegal=0, OutValid=0, InReady=1. Any in-flight op is discarded.
- 1-cycle ops and shifts by 0: accepted at edge N, OutValid=1 after edge N+1.
- Shift by k (1..2^SHW-1): accepted at edge N, OutValid=1 after edge N+1+k.
- Outputs are stable while OutValid=1 && OutReady=0; a stall can last any number of cycles.
- OutValid and InReady are never high together. After OutReady at edge M, InReady=1 after edge M; the earliest next accept is edge M+1, so there is one bubble between results.
- InValid while busy is ignored; the source holds its request.
- OutReady while OutValid=0 has no effect.

## Structure
- The shared package (definitions) gains:
  - typedef enum logic[1:0] {IDLE, SHIFT, DONE} alu_state_t
  - kOPMAX = kSLT, used for the Illegal decode
  - The opcode constants are not duplicated.
- Sub-module alu_comb: purely combinational. Takes Op, A, B and produces result, carry and illegal for all non-shift ops. alu_iter instantiates it and owns the FSM, the shift counter and the output registers.

## Test plan
- Reset mid-SHIFT: LSH A=8'h01, B=7; assert Reset at cycle 3 -> next cycle OutValid=0, InReady=1, Out=0. A fresh ADD then completes normally.
- ADD A=8'hF0, B=8'h20 -> Out=8'h10, Carry=1, Zero=0, OutValid one cycle after accept. SUB A=3, B=5 -> Out=8'hFE, Carry=1.
- SLT A=8'hFF, B=8'h01 -> Out=1. SEQ A=B=8'h5A -> Out=1, Zero=0. XOR A=B=8'h5A -> Out=0, Zero=1.
- RSH A=8'h80, B=8'h07 -> Out=8'h01, OutValid exactly 8 cycles after accept. LSH B=8'h08 (low bits 0) -> Out=A, 1-cycle latency.
- Op=4'hC with A=B=8'hFF -> Illegal=1, Out=0, Zero=1, Carry=0.
- Backpressure: hold OutReady=0 for 5 cycles after an ADD -> Out stable, InReady=0, extra InValid ignored. Release -> InReady=1 next cycle, next op accepted the following edge.
